cp0_unit: RTL

Coprocessor-0 register block; the responder for the decode stage's CP0 read channel (cp_read_en/addr -> data) and the target of the write-back stage's CP0 write channel (cp_write_en/addr + data).
Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14) and PRId(15).
Runs the Count/Compare timer, latches exception state from the MEM stage, and produces the pending-interrupt flag consumed by the exception logic.

---
 rtl/cp0_unit_pkg.sv | 50 +++++
 rtl/cp0_timer.sv | 51 +++++
 rtl/cp0_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// ============================================================================
// Module  : cp0_unit_pkg
// Brief   : CP0 register numbers, field positions, write masks and ExcCodes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_unit_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [REG_ADDR_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [REG_ADDR_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [REG_ADDR_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [REG_ADDR_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [REG_ADDR_W-1:0] CP0_EPC      = 5'd14;
  localparam logic [REG_ADDR_W-1:0] CP0_PRID     = 5'd15;

  localparam int STATUS_IE   = 0;
  localparam int STATUS_EXL  = 1;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [DATA_W-1:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [DATA_W-1:0] FULL_WMASK   = 32'hFFFF_FFFF;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  function automatic logic [DATA_W-1:0] cp0_wmask(input logic [REG_ADDR_W-1:0] addr);
    case (addr)
      CP0_STATUS:                     return STATUS_WMASK;
      CP0_CAUSE:                      return CAUSE_WMASK;
      CP0_EPC, CP0_COUNT, CP0_COMPARE: return FULL_WMASK;
      default:                        return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module  : cp0_timer
// Brief   : Count/Compare timer with sticky timer interrupt.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_timer
  import cp0_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_count,
  input  logic              i_load_compare,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_count,
  output logic [DATA_W-1:0] o_compare,
  output logic              o_timer_int
);

  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_compare;
  logic              r_timer_int;
  logic              w_match;

  assign w_match = (r_compare != '0) && (r_count == r_compare);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_compare   <= '0;
      r_timer_int <= 1'b0;
    end else begin
      r_count <= i_load_count ? i_wdata : r_count + 32'd1;
      if (i_load_compare)
        r_compare <= i_wdata;
      // Compare write acknowledges the interrupt and beats a same-cycle match.
      if (i_load_compare)
        r_timer_int <= 1'b0;
      else if (w_match)
        r_timer_int <= 1'b1;
    end
  end

  assign o_count     = r_count;
  assign o_compare   = r_compare;
  assign o_timer_int = r_timer_int;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
// Module  : cp0_unit
// Brief   : CP0 register block: read/write channels, exception state, IRQs.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0001_8000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [4:0]  read_addr,
  output logic [31:0] read_data,
  input  logic        write_en,
  input  logic [4:0]  write_addr,
  input  logic [31:0] write_data,
  input  logic [5:0]  int_in,
  input  logic        exc_en,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_delayslot,
  input  logic        exc_badvaddr_en,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic        timer_int,
  output logic        int_pending,
  output logic [31:0] epc_out,
  output logic [31:0] status_out,
  output logic [31:0] cause_out
);

  logic [DATA_W-1:0] r_status;
  logic [DATA_W-1:0] r_cause;
  logic [DATA_W-1:0] r_epc;
  logic [DATA_W-1:0] r_badvaddr;
  logic [DATA_W-1:0] w_count;
  logic [DATA_W-1:0] w_compare;
  logic              w_timer_int;
  logic              w_trap;
  logic              w_wr_status;
  logic              w_wr_cause;
  logic              w_wr_epc;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_rmask;

  assign w_trap      = exc_en | eret;
  assign w_wr_status = write_en && (write_addr == CP0_STATUS) && !w_trap;
  assign w_wr_cause  = write_en && (write_addr == CP0_CAUSE)  && !w_trap;
  assign w_wr_epc    = write_en && (write_addr == CP0_EPC)    && !w_trap;

  cp0_timer u_timer (
    .clk            (clk),
    .rst            (rst),
    .i_load_count   (write_en && (write_addr == CP0_COUNT)),
    .i_load_compare (write_en && (write_addr == CP0_COMPARE)),
    .i_wdata        (write_data),
    .o_count        (w_count),
    .o_compare      (w_compare),
    .o_timer_int    (w_timer_int)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status   <= STATUS_RESET;
      r_cause    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_cause[15:10] <= {int_in[5] | w_timer_int, int_in[4:0]};
      if (exc_en) begin
        r_status[STATUS_EXL] <= 1'b1;
        r_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= exc_code;
        // A nested exception keeps the EPC/BD of the outermost one.
        if (!r_status[STATUS_EXL]) begin
          r_epc             <= exc_delayslot ? exc_pc - 32'd4 : exc_pc;
          r_cause[CAUSE_BD] <= exc_delayslot;
        end
        if (exc_badvaddr_en)
          r_badvaddr <= exc_badvaddr;
      end else if (eret) begin
        r_status[STATUS_EXL] <= 1'b0;
      end else begin
        if (w_wr_status)
          r_status <= (r_status & ~STATUS_WMASK) | (write_data & STATUS_WMASK);
        if (w_wr_cause)
          r_cause[9:8] <= write_data[9:8];
        if (w_wr_epc)
          r_epc <= write_data;
      end
    end
  end

  always_comb begin
    w_cur = '0;
    case (read_addr)
      CP0_BADVADDR: w_cur = r_badvaddr;
      CP0_COUNT:    w_cur = w_count;
      CP0_COMPARE:  w_cur = w_compare;
      CP0_STATUS:   w_cur = r_status;
      CP0_CAUSE:    w_cur = r_cause;
      CP0_EPC:      w_cur = r_epc;
      CP0_PRID:     w_cur = PRID_VALUE;
      default:      w_cur = '0;
    endcase
  end

  // Same-cycle write forwards the value the register is about to take.
  assign w_rmask = cp0_wmask(read_addr);

  always_comb begin
    read_data = '0;
    if (read_en) begin
      if (write_en && (write_addr == read_addr))
        read_data = (w_cur & ~w_rmask) | (write_data & w_rmask);
      else
        read_data = w_cur;
    end
  end

  assign int_pending = r_status[STATUS_IE] & ~r_status[STATUS_EXL] &
                       (|(r_cause[15:8] & r_status[15:8]));
  assign timer_int   = w_timer_int;
  assign epc_out     = r_epc;
  assign status_out  = r_status;
  assign cause_out   = r_cause;

endmodule

`default_nettype wire
